// File: rtl/datapath_pkg.sv
// Shared definitions for the three-stage datapath: ALU opcodes, instruction
// field positions and the pipeline stage register layouts.
package datapath_pkg;

    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 5;
    localparam int OP_W        = 4;
    localparam int IMM_W       = 16;

    localparam int IMM_SEL_BIT = 30;
    localparam int OP_MSB      = 29;
    localparam int OP_LSB      = 26;
    localparam int RS_MSB      = 25;
    localparam int RS_LSB      = 21;
    localparam int RT_MSB      = 20;
    localparam int RT_LSB      = 16;
    localparam int RD_MSB      = 15;
    localparam int RD_LSB      = 11;
    localparam int IMM_MSB     = 15;
    localparam int IMM_LSB     = 0;

    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_XOR = 4'b0011;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLL = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SRL = 4'b1001;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic               w_en;
        logic               sel;
        logic               valid;
    } stage_t;

    // WB only needs the destination and control bits of the instruction
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic              w_en;
        logic              sel;
        logic              valid;
    } wb_stage_t;

    function automatic logic [ADDR_W-1:0] field_rs(input logic [INSTR_W-1:0] ir);
        return ir[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] field_rt(input logic [INSTR_W-1:0] ir);
        return ir[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] field_rd(input logic [INSTR_W-1:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [OP_W-1:0] field_op(input logic [INSTR_W-1:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [IMM_W-1:0] field_imm(input logic [INSTR_W-1:0] ir);
        return ir[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/pipelined_datapath_if.sv
// Instruction / load-data / write-back bundle between the control side
// (master) and the datapath (slave).
interface pipelined_datapath_if
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   ir_input;
    logic                 w_en;
    logic                 register_file_select;
    logic [WIDTH-1:0]     data_input;
    logic                 data_valid;
    logic [WIDTH-1:0]     alu_output;
    logic                 alu_zero;
    logic                 out_valid;
    logic [ADDR_W-1:0]    wb_addr;

    modport master (
        output in_valid, ir_input, w_en, register_file_select, data_input, data_valid,
        input  in_ready, alu_output, alu_zero, out_valid, wb_addr
    );

    modport slave (
        input  in_valid, ir_input, w_en, register_file_select, data_input, data_valid,
        output in_ready, alu_output, alu_zero, out_valid, wb_addr
    );
endinterface

// File: rtl/alu_core.sv
// Combinational ALU: wrap-around arithmetic, signed SLT, 5-bit shift amount,
// unknown opcodes produce zero.
module alu_core
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_NOR: result = ~(a | b);
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/pipelined_datapath.sv
// Three-stage datapath (ID latch, EX operand read + ALU, WB write-back) with
// a load-data stall, WB->EX forwarding and an optional hardwired-zero r0.
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int REGS     = 32,
    parameter bit SIGN_EXT = 1'b0,
    parameter bit R0_ZERO  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    pipelined_datapath_if.slave  bus
);

    stage_t             id_reg;
    wb_stage_t          wb_reg;
    logic [WIDTH-1:0]   alu_out_reg;
    logic               alu_zero_reg;
    logic [WIDTH-1:0]   regs [REGS];

    logic               stall;
    logic               wb_write;
    logic               wb_drop;
    logic               fwd_ok;
    logic [REGS-1:0]    reg_we;
    logic [WIDTH-1:0]   wb_value;

    logic [ADDR_W-1:0]  rs;
    logic [ADDR_W-1:0]  rt;
    logic [IMM_W-1:0]   imm;
    logic [WIDTH-1:0]   imm_ext;
    logic [WIDTH-1:0]   rf_a;
    logic [WIDTH-1:0]   rf_b;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_z;
    logic               unused_bits;

    // A load sitting in WB without its data freezes the whole pipe
    assign stall    = wb_reg.valid & wb_reg.sel & ~bus.data_valid;
    assign wb_value = wb_reg.sel ? bus.data_input : alu_out_reg;
    assign wb_drop  = (R0_ZERO && (wb_reg.rd == '0)) || (int'(wb_reg.rd) >= REGS);
    assign fwd_ok   = wb_reg.valid & wb_reg.w_en & ~wb_drop;
    assign wb_write = fwd_ok & ~stall;

    assign rs  = field_rs(id_reg.instr);
    assign rt  = field_rt(id_reg.instr);
    assign imm = field_imm(id_reg.instr);
    assign unused_bits = id_reg.instr[INSTR_W-1];

    always_comb begin
        if (SIGN_EXT) imm_ext = WIDTH'($signed(imm));
        else          imm_ext = WIDTH'(imm);
    end

    always_comb begin
        rf_a = '0;
        rf_b = '0;
        for (int i = 0; i < REGS; i++) begin
            if (rs == ADDR_W'(i)) rf_a = regs[i];
            if (rt == ADDR_W'(i)) rf_b = regs[i];
        end
    end

    // During the data_valid cycle of a load, the forwarded value is data_input itself
    always_comb begin
        op_a = (fwd_ok && (wb_reg.rd == rs)) ? wb_value : rf_a;
        if (id_reg.instr[IMM_SEL_BIT])
            op_b = imm_ext;
        else
            op_b = (fwd_ok && (wb_reg.rd == rt)) ? wb_value : rf_b;
    end

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .op     (field_op(id_reg.instr)),
        .a      (op_a),
        .b      (op_b),
        .result (alu_res),
        .zero   (alu_z)
    );

    for (genvar gi = 0; gi < REGS; gi++) begin : g_we
        assign reg_we[gi] = wb_write && (wb_reg.rd == ADDR_W'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < REGS; i++) begin
                if (reg_we[i]) regs[i] <= wb_value;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_reg       <= '0;
            wb_reg       <= '0;
            alu_out_reg  <= '0;
            alu_zero_reg <= 1'b0;
        end else if (!stall) begin
            if (bus.in_valid)
                id_reg <= '{instr: bus.ir_input, w_en: bus.w_en,
                            sel: bus.register_file_select, valid: 1'b1};
            else
                id_reg.valid <= 1'b0;
            wb_reg <= '{rd: field_rd(id_reg.instr), w_en: id_reg.w_en,
                        sel: id_reg.sel, valid: id_reg.valid};
            // Bubbles leave the last result visible
            if (id_reg.valid) begin
                alu_out_reg  <= alu_res;
                alu_zero_reg <= alu_z;
            end
        end
    end

    assign bus.in_ready   = ~stall;
    assign bus.alu_output = alu_out_reg;
    assign bus.alu_zero   = alu_zero_reg;
    assign bus.out_valid  = wb_reg.valid;
    assign bus.wb_addr    = wb_reg.rd;

endmodule

// File: tb/tb_pipelined_datapath.sv
// Randomized + directed bench: two instances (zero- and sign-extending) share
// stimulus and are checked against an in-order ISA model with a timing model.
module tb_pipelined_datapath;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipelined_datapath_if #(.WIDTH(32)) bus0 ();
    pipelined_datapath_if #(.WIDTH(32)) bus1 ();

    assign bus1.in_valid             = bus0.in_valid;
    assign bus1.ir_input             = bus0.ir_input;
    assign bus1.w_en                 = bus0.w_en;
    assign bus1.register_file_select = bus0.register_file_select;
    assign bus1.data_input           = bus0.data_input;
    assign bus1.data_valid           = bus0.data_valid;

    pipelined_datapath #(.WIDTH(32), .REGS(32), .SIGN_EXT(1'b0), .R0_ZERO(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    pipelined_datapath #(.WIDTH(32), .REGS(32), .SIGN_EXT(1'b1), .R0_ZERO(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct {
        bit          valid;
        bit          load;
        int          waits;
        logic [31:0] ld;
        logic [31:0] res0;
        logic [31:0] res1;
        logic [4:0]  rd;
    } slot_t;

    slot_t       id_s, wb_s;
    logic [31:0] arch0 [32];
    logic [31:0] arch1 [32];
    logic [31:0] last0, last1;
    bit          lastz0, lastz1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            4'b0011: return a ^ b;
            4'b1000: return a << b[4:0];
            4'b1001: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {2'b00, op, rs, rt, rd, 11'd0};
    endfunction

    function automatic logic [31:0] mki(input logic [3:0] op, input logic [4:0] rs, input logic [15:0] imm);
        return {2'b01, op, rs, 5'd0, imm};
    endfunction

    // In-order architectural execution; both sign-extension flavours side by side
    task automatic execute(input logic [31:0] ir, input bit we, input bit ld_sel, input logic [31:0] ld_data,
                           output logic [31:0] res0, output logic [31:0] res1);
        logic [4:0]  rs, rt, rd;
        logic [31:0] b0, b1;
        rs = ir[25:21];
        rt = ir[20:16];
        rd = ir[15:11];
        if (ir[30]) begin
            b0 = {16'h0000, ir[15:0]};
            b1 = {{16{ir[15]}}, ir[15:0]};
        end else begin
            b0 = arch0[rt];
            b1 = arch1[rt];
        end
        res0 = alu_ref(ir[29:26], arch0[rs], b0);
        res1 = alu_ref(ir[29:26], arch1[rs], b1);
        if (we && rd != 5'd0) begin
            arch0[rd] = ld_sel ? ld_data : res0;
            arch1[rd] = ld_sel ? ld_data : res1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            arch0[i] = '0;
            arch1[i] = '0;
        end
        id_s.valid = 1'b0;
        wb_s.valid = 1'b0;
        last0 = '0;
        last1 = '0;
        lastz0 = 1'b0;
        lastz1 = 1'b0;
    endtask

    // One clock cycle: drive, check ready, advance the timing model, check outputs
    task automatic cycle(input bit iv, input logic [31:0] ir, input bit we, input bit sel,
                         input logic [31:0] ld, input int waits, output bit acc);
        bit          stall_exp;
        logic [31:0] r0v, r1v;
        bus0.in_valid = iv;
        bus0.ir_input = ir;
        bus0.w_en = we;
        bus0.register_file_select = sel;
        stall_exp = wb_s.valid && wb_s.load && (wb_s.waits > 0);
        if (wb_s.valid && wb_s.load) begin
            bus0.data_valid = !stall_exp;
            bus0.data_input = stall_exp ? $urandom : wb_s.ld;
        end else begin
            bus0.data_valid = 1'($urandom_range(0, 1));
            bus0.data_input = $urandom;
        end
        #1;
        chk("in_ready0", {31'd0, bus0.in_ready}, {31'd0, !stall_exp});
        chk("in_ready1", {31'd0, bus1.in_ready}, {31'd0, !stall_exp});
        @(posedge clk);
        acc = iv && !stall_exp;
        if (stall_exp) begin
            wb_s.waits--;
        end else begin
            wb_s = id_s;
            if (acc) begin
                execute(ir, we, sel, ld, r0v, r1v);
                id_s.valid = 1'b1;
                id_s.load  = sel;
                id_s.waits = waits;
                id_s.ld    = ld;
                id_s.res0  = r0v;
                id_s.res1  = r1v;
                id_s.rd    = ir[15:11];
            end else begin
                id_s.valid = 1'b0;
            end
            if (wb_s.valid) begin
                last0 = wb_s.res0;
                last1 = wb_s.res1;
                lastz0 = (wb_s.res0 == 32'd0);
                lastz1 = (wb_s.res1 == 32'd0);
            end
        end
        @(negedge clk);
        chk("out_valid0", {31'd0, bus0.out_valid}, {31'd0, wb_s.valid});
        chk("out_valid1", {31'd0, bus1.out_valid}, {31'd0, wb_s.valid});
        chk("alu_output0", bus0.alu_output, last0);
        chk("alu_output1", bus1.alu_output, last1);
        chk("alu_zero0", {31'd0, bus0.alu_zero}, {31'd0, lastz0});
        chk("alu_zero1", {31'd0, bus1.alu_zero}, {31'd0, lastz1});
        if (wb_s.valid) begin
            chk("wb_addr0", {27'd0, bus0.wb_addr}, {27'd0, wb_s.rd});
            chk("wb_addr1", {27'd0, bus1.wb_addr}, {27'd0, wb_s.rd});
        end
    endtask

    task automatic issue(input string name, input logic [31:0] ir, input bit we, input bit sel,
                         input logic [31:0] ld, input int waits);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 40) begin
            cycle(1'b1, ir, we, sel, ld, waits, acc);
            n++;
        end
        chk({"accept_", name}, {31'd0, acc}, 32'd1);
        $display("txn %-10s ir=%h we=%0d load=%0d ld=%h waits=%0d cycles=%0d",
                 name, ir, we, sel, ld, waits, n);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b0, 1'b0, 32'd0, 0, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ir;
        logic [3:0]  op;
        bit          we, sel, acc;
        int          waits;

        bus0.in_valid = 1'b0;
        bus0.ir_input = '0;
        bus0.w_en = 1'b0;
        bus0.register_file_select = 1'b0;
        bus0.data_input = '0;
        bus0.data_valid = 1'b0;
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus0.out_valid}, 32'd0);
        chk("rst_alu_output", bus0.alu_output, 32'd0);
        chk("rst_alu_zero", {31'd0, bus0.alu_zero}, 32'd0);
        chk("rst_wb_addr", {27'd0, bus0.wb_addr}, 32'd0);
        chk("rst_out_valid1", {31'd0, bus1.out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);

        issue("rd_r5",   mk(4'b0001, 5'd5, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        issue("ld_r1",   mk(4'b0000, 5'd0, 5'd0, 5'd1), 1'b1, 1'b1, 32'd5, 0);
        issue("ld_r2",   mk(4'b0000, 5'd0, 5'd0, 5'd2), 1'b1, 1'b1, 32'd7, 0);
        issue("add_r3",  mk(4'b0010, 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 32'd0, 0);
        issue("sub_r4",  mk(4'b0110, 5'd3, 5'd1, 5'd4), 1'b1, 1'b0, 32'd0, 0);
        issue("add_r5",  mk(4'b0010, 5'd4, 5'd4, 5'd5), 1'b1, 1'b0, 32'd0, 0);
        issue("rd_r3",   mk(4'b0001, 5'd3, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        issue("rd_r5b",  mk(4'b0001, 5'd5, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        issue("addi_ff", mki(4'b0010, 5'd0, 16'hFFFF), 1'b1, 1'b0, 32'd0, 0);
        issue("rd_r31",  mk(4'b0001, 5'd31, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        issue("addi_r0", mki(4'b0010, 5'd1, 16'h07FF), 1'b1, 1'b0, 32'd0, 0);
        issue("rd_r0",   mk(4'b0001, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        issue("ld_r6",   mk(4'b0000, 5'd0, 5'd0, 5'd6), 1'b1, 1'b1, 32'd9, 3);
        issue("addi_r6", mki(4'b0010, 5'd6, 16'h0001), 1'b1, 1'b0, 32'd0, 0);
        idle(3);

        for (int k = 0; k < 150; k++) begin
            op  = 4'($urandom_range(0, 15));
            ir  = {1'b0, 1'($urandom_range(0, 1)), op, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
            if (ir[30]) ir[15:0] = 16'($urandom);
            sel   = ($urandom_range(0, 3) == 0);
            we    = ($urandom_range(0, 3) != 0);
            waits = sel ? $urandom_range(0, 3) : 0;
            issue("rand", ir, we, sel, $urandom, waits);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(2);

        issue("ld_r1b",  mk(4'b0000, 5'd0, 5'd0, 5'd1), 1'b1, 1'b1, 32'hDEAD_BEEF, 0);
        issue("ld_long", mk(4'b0000, 5'd0, 5'd0, 5'd7), 1'b1, 1'b1, 32'h1234, 6);
        idle(2);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_out_valid0", {31'd0, bus0.out_valid}, 32'd0);
        chk("midrst_out_valid1", {31'd0, bus1.out_valid}, 32'd0);
        chk("midrst_alu_output", bus0.alu_output, 32'd0);
        chk("midrst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
        model_reset();
        $display("txn reset_mid_stall");
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, mk(4'b0001, 5'd1, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0, acc);
        chk("first_accept", {31'd0, acc}, 32'd1);
        $display("txn rd_r1_after_reset accepted=%0d", acc);
        issue("rd_r7",   mk(4'b0001, 5'd7, 5'd0, 5'd0), 1'b0, 1'b0, 32'd0, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_datapath.md
Name: pipelined_datapath

Overview:
- Parametrised, three-stage successor to the single-cycle 32-bit datapath: IR latch (ID), operand read + ALU (EX), register write-back (WB).
- Adds a valid/ready instruction handshake, a load-data wait handshake, EX←WB operand forwarding, selectable immediate extension and a hardwired-zero r0.
- Sits between instruction fetch/control and the memory interface of the CPU.

Parameters:
WIDTH, 32, datapath/register width; legal range 16..64.
REGS, 32, register count; 5-bit address fields, so REGS ≤ 32.
SIGN_EXT, 0, 0 = zero-extend imm[15:0]; 1 = sign-extend.
R0_ZERO, 1, 1 = r0 reads 0 and ignores writes.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
in_valid  in  1  ir_input/w_en/register_file_select valid
in_ready  out  1  datapath can accept an instruction
ir_input  in  32  instruction: [30]=use imm, [29:26]=alu op, [25:21]=rs, [20:16]=rt, [15:11]=rd, [15:0]=imm
w_en  in  1  instruction writes rd
register_file_select  in  1  1 = write data_input (load), 0 = write ALU result
data_input  in  WIDTH  load data
data_valid  in  1  data_input valid this cycle
alu_output  out  WIDTH  registered EX result (WB stage)
alu_zero  out  1  registered: alu_output == 0
out_valid  out  1  WB stage holds a valid instruction
wb_addr  out  5  rd of the WB instruction

Behaviour:
- Reset (reset=0, async): all registers cleared, ID/WB valid=0, alu_output=0, alu_zero=0, out_valid=0, wb_addr=0. in_ready=1 once reset is released.
- stall = WB valid & WB load & !data_valid. in_ready = !stall.
- While stalled, all stage registers hold and no register-file write occurs.
- ID: on a handshake edge (in_valid & in_ready), capture ir_input, w_en and register_file_select, and set ID valid. Otherwise, when not stalled, clear ID valid.
- EX (combinational from ID):
  - A = reg[rs]; B = ir[30] ? ext(imm) : reg[rt].
  - Forwarding: if WB valid & WB w_en & WB rd == rs (resp. rt, when B uses rt) and !(R0_ZERO & rd == 0), substitute the WB value. The WB value is data_input for a load, else alu_output.
- ALU ops, 4-bit, WIDTH-bit wrap-around (carry/overflow discarded):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 0011 XOR, 1000 SLL by B[4:0], 1001 SRL by B[4:0].
  - Any other op → 0.
- EX→WB edge (not stalled): alu_output, alu_zero, rd, w_en, select and valid are loaded from ID. A bubble sets out_valid=0; alu_output holds its old value.
- WB: at the edge where WB valid & w_en & !stall, write reg[rd] with the WB value. With R0_ZERO=1, rd=0 writes are dropped.
- Latency: instruction accepted at edge E0 → out_valid high after E1 → register written at E2 (later if stalled). Throughput is 1 instruction/cycle when there are no load stalls.
- A back-to-back dependency is resolved by forwarding with no bubble.
- A load followed by a dependent instruction is stalled until data_valid; the forwarded value is data_input in that same cycle.
- If in_valid is asserted during a stall, the instruction is not accepted; the source must hold it.
- Reset mid-stall discards both in-flight instructions; register contents are cleared.

Decomposition:
- Package datapath_pkg: ALU op localparams; instruction field bit positions (IMM_SEL_BIT=30, OP_MSB/LSB, RS/RT/RD ranges); stage-register struct typedef (instr, w_en, sel, valid).
- One sub-module, alu_core #(WIDTH): combinational op/A/B → result, zero.
- The register file stays inline (2R1W, async read).

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, alu_output=0; any register reads 0.
- Load r1=5, r2=7 via register_file_select=1, data_valid=1; then ADD r3=r1+r2, op 0010 → alu_output=12 two edges after acceptance; r3 later reads 12.
- Back-to-back SUB r4=r3-r1, then ADD r5=r4+r4 → forwarding gives r5=14; no stall, in_ready stays 1.
- Immediate with imm=16'hFFFF: SIGN_EXT=0, ADD r0-relative → 32'h0000FFFF; SIGN_EXT=1 → 32'hFFFFFFFF. Write to rd=0 is ignored and r0 stays 0.
- Load with data_valid=0 for 3 cycles, then 1 with data_input=9; dependent ADD r6=r6+imm 1 → in_ready=0 for 3 cycles; result 10; pipeline state is held throughout.
- Assert reset during a stall → out_valid=0 immediately; after release, r1 reads 0 and a new instruction is accepted on the first edge.
